// File: rtl/data_memory_debug_arbiter.sv
// rtl/data_memory_debug_arbiter.sv - data RAM owner shared by the MEM stage and a debug burst-dump engine
// The pipeline drives the RAM directly only while idle; a burst walks base..base+len-1 one word per handshake.
module data_memory_debug_arbiter #(
  parameter int Addr_B  = 10,
  parameter int Width_B = 32,
  parameter int Len_B   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pipeMemRead,
  input  logic               pipeMemWrite,
  input  logic [Addr_B-1:0]  pipeAddress,
  input  logic [Width_B-1:0] pipeWriteData,
  output logic [Width_B-1:0] pipeReadData,
  output logic               pipeStall,
  input  logic               dbgStart,
  input  logic [Addr_B-1:0]  dbgBaseAddr,
  input  logic [Len_B-1:0]   dbgLength,
  output logic [Width_B-1:0] dbgData,
  output logic               dbgDataValid,
  input  logic               dbgDataReady,
  output logic               dbgBusy,
  output logic               dbgDone,
  output logic               memWriteEnable,
  output logic [Addr_B-1:0]  memAddress,
  output logic [Width_B-1:0] memWriteData,
  input  logic [Width_B-1:0] memReadData
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, OUT, DONE} state_t;

  state_t            state;
  logic [Addr_B-1:0] base;
  logic [Len_B-1:0]  length;
  logic [Len_B-1:0]  count;
  logic              idle;
  logic              lastWord;

  assign idle     = (state == IDLE);
  assign lastWord = (count == length - Len_B'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      base         <= '0;
      length       <= '0;
      count        <= '0;
      dbgData      <= '0;
      dbgDataValid <= 1'b0;
      dbgBusy      <= 1'b0;
      dbgDone      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dbgStart) begin
            base    <= dbgBaseAddr;
            length  <= dbgLength;
            count   <= '0;
            dbgBusy <= (dbgLength != '0);
            dbgDone <= (dbgLength == '0);
            state   <= (dbgLength == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          dbgData      <= memReadData;
          dbgDataValid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          // Address stays parked on the current word until the consumer takes it
          if (dbgDataReady) begin
            dbgDataValid <= 1'b0;
            count        <= count + Len_B'(1);
            if (lastWord) begin
              dbgBusy <= 1'b0;
              dbgDone <= 1'b1;
              state   <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          dbgDone <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read wins over write when the MEM stage asserts both
  always_comb begin
    memAddress     = base + Addr_B'(count);
    memWriteData   = pipeWriteData;
    memWriteEnable = 1'b0;
    if (idle) begin
      memAddress     = pipeAddress;
      memWriteEnable = pipeMemWrite & ~pipeMemRead;
    end
  end

  assign pipeStall    = ~idle & (pipeMemRead | pipeMemWrite);
  assign pipeReadData = memReadData;

endmodule

// File: tb/tb_data_memory_debug_arbiter.sv
// tb/tb_data_memory_debug_arbiter.sv - self-checking bench with a behavioural RAM and burst reference model
module tb_data_memory_debug_arbiter;
  logic        clk;
  logic        reset;
  logic        pipeMemRead, pipeMemWrite;
  logic [9:0]  pipeAddress;
  logic [31:0] pipeWriteData, pipeReadData;
  logic        pipeStall;
  logic        dbgStart;
  logic [9:0]  dbgBaseAddr, dbgLength;
  logic [31:0] dbgData;
  logic        dbgDataValid, dbgDataReady, dbgBusy, dbgDone;
  logic        memWriteEnable;
  logic [9:0]  memAddress;
  logic [31:0] memWriteData, memReadData;

  data_memory_debug_arbiter #(.Addr_B(10), .Width_B(32), .Len_B(10)) dut (
    .clk(clk), .reset(reset),
    .pipeMemRead(pipeMemRead), .pipeMemWrite(pipeMemWrite), .pipeAddress(pipeAddress),
    .pipeWriteData(pipeWriteData), .pipeReadData(pipeReadData), .pipeStall(pipeStall),
    .dbgStart(dbgStart), .dbgBaseAddr(dbgBaseAddr), .dbgLength(dbgLength),
    .dbgData(dbgData), .dbgDataValid(dbgDataValid), .dbgDataReady(dbgDataReady),
    .dbgBusy(dbgBusy), .dbgDone(dbgDone),
    .memWriteEnable(memWriteEnable), .memAddress(memAddress), .memWriteData(memWriteData),
    .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initVal(input int i);
    if (i >= 8 && i <= 11) return 32'h10 + 32'(i - 8);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Behavioural single-port RAM with one cycle of read latency
  logic [31:0] ram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = initVal(i);
    memReadData = '0;
    forever begin
      @(posedge clk);
      if (memWriteEnable) ram[memAddress] <= memWriteData;
      memReadData <= ram[memAddress];
    end
  end

  logic [31:0] model [1024];
  int nChecks, nErrors;

  logic [31:0] gotQ[$];
  int          gotCyc[$];
  logic [9:0]  addrQ[$];
  int          doneCount, doneCyc, holdBad, addrBad, stallBad, validSeen;

  task automatic do_burst(input logic [9:0] b, input logic [9:0] l, input int readyMode,
                          input int stallWord, input int stallCycles, input bit pipeWr, input bit restart);
    logic [31:0] prevData;
    bit          prevPending, haveAddr;
    int          held;
    logic [9:0]  lastAddr;
    gotQ.delete(); gotCyc.delete(); addrQ.delete();
    doneCount = 0; doneCyc = -1; holdBad = 0; addrBad = 0; stallBad = 0; validSeen = 0;
    prevPending = 0; haveAddr = 0; held = 0; prevData = '0; lastAddr = '0;
    @(negedge clk);
    dbgStart = 1; dbgBaseAddr = b; dbgLength = l; dbgDataReady = 1;
    for (int c = 1; c <= 300 && doneCount == 0; c++) begin
      @(negedge clk);
      dbgStart = 0;
      if (restart && c == 4) begin
        dbgStart = 1; dbgBaseAddr = b + 10'd100; dbgLength = 10'd7;
      end
      if (pipeWr && c == 1) begin
        pipeMemWrite = 1; pipeAddress = 10'd9; pipeWriteData = 32'hAA;
      end
      if (readyMode == 1) dbgDataReady = 1'($urandom_range(0, 1));
      else if (gotQ.size() == stallWord && dbgDataValid && held < stallCycles) begin
        dbgDataReady = 0; held++;
      end else dbgDataReady = 1;
      #1;
      if (prevPending && (!dbgDataValid || dbgData !== prevData)) holdBad++;
      if (dbgBusy && (!haveAddr || memAddress !== lastAddr)) begin
        addrQ.push_back(memAddress); lastAddr = memAddress; haveAddr = 1;
      end
      if (dbgDataValid && !dbgDataReady && memAddress !== b + 10'(gotQ.size())) addrBad++;
      if ((dbgBusy || dbgDone) && (pipeMemRead || pipeMemWrite) && !pipeStall) stallBad++;
      if ((dbgBusy || dbgDone) && memWriteEnable) stallBad++;
      if (dbgDataValid) validSeen++;
      if (dbgDataValid && dbgDataReady) begin
        gotQ.push_back(dbgData); gotCyc.push_back(c); prevPending = 0;
      end else begin
        prevPending = dbgDataValid; prevData = dbgData;
      end
      if (dbgDone) begin doneCount++; doneCyc = c; end
    end
    dbgStart = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    nChecks++;
    if ({dbgDataValid, dbgBusy, dbgDone, pipeStall, memWriteEnable} !== 5'b0) begin
      nErrors++; $display("FAIL reset_outputs: got %b expected 00000",
                          {dbgDataValid, dbgBusy, dbgDone, pipeStall, memWriteEnable});
    end
    nChecks++;
    if (dbgData !== 32'h0) begin nErrors++; $display("FAIL reset_dbgData: got %h expected 0", dbgData); end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_pipeline;
    int stallSeen = 0;
    @(negedge clk);
    pipeMemWrite = 1; pipeAddress = 10'd5; pipeWriteData = 32'hDEADBEEF;
    #1;
    nChecks++;
    if (memWriteEnable !== 1'b1 || memAddress !== 10'd5) begin
      nErrors++; $display("FAIL pipe_write_en: got we=%b addr=%h expected we=1 addr=005", memWriteEnable, memAddress);
    end
    if (pipeStall) stallSeen++;
    model[5] = 32'hDEADBEEF;
    @(negedge clk);
    pipeMemRead = 1; pipeWriteData = 32'h00000123;
    #1;
    nChecks++;
    if (memWriteEnable !== 1'b0) begin
      nErrors++; $display("FAIL pipe_read_wins: got we=%b expected 0", memWriteEnable);
    end
    if (pipeStall) stallSeen++;
    @(negedge clk);
    pipeMemRead = 0; pipeMemWrite = 0;
    #1;
    nChecks++;
    if (pipeReadData !== model[5]) begin
      nErrors++; $display("FAIL pipe_read_data: got %h expected %h", pipeReadData, model[5]);
    end
    nChecks++;
    if (stallSeen != 0) begin nErrors++; $display("FAIL pipe_no_stall: got %0d stall cycles expected 0", stallSeen); end
  endtask

  task automatic test_burst;
    do_burst(10'd8, 10'd4, 0, -1, 0, 0, 0);
    nChecks++;
    if (gotQ.size() != 4) begin nErrors++; $display("FAIL burst_count: got %0d expected 4", gotQ.size()); end
    for (int k = 0; k < gotQ.size(); k++) begin
      nChecks++;
      if (gotQ[k] !== 32'h10 + 32'(k) || gotCyc[k] != 3 + 3 * k) begin
        nErrors++; $display("FAIL burst_word%0d: got %h at cycle %0d expected %h at cycle %0d",
                            k, gotQ[k], gotCyc[k], 32'h10 + 32'(k), 3 + 3 * k);
      end
    end
    nChecks++;
    if (doneCount != 1 || doneCyc != 13) begin
      nErrors++; $display("FAIL burst_done: got %0d pulses at cycle %0d expected 1 at 13", doneCount, doneCyc);
    end
    @(negedge clk); #1;
    nChecks++;
    if (dbgBusy !== 1'b0 || dbgDone !== 1'b0) begin
      nErrors++; $display("FAIL burst_after: got busy=%b done=%b expected 0 0", dbgBusy, dbgDone);
    end
  endtask

  task automatic test_backpressure;
    do_burst(10'd8, 10'd4, 0, 1, 5, 0, 0);
    nChecks++;
    if (gotQ.size() != 4 || gotQ[0] !== 32'h10 || gotQ[1] !== 32'h11 || gotQ[2] !== 32'h12 || gotQ[3] !== 32'h13) begin
      nErrors++; $display("FAIL bp_words: got %0d words expected 10,11,12,13", gotQ.size());
    end
    nChecks++;
    if (holdBad != 0 || addrBad != 0) begin
      nErrors++; $display("FAIL bp_hold: got holdBad=%0d addrBad=%0d expected 0 0", holdBad, addrBad);
    end
    nChecks++;
    if (doneCyc != 18 || doneCount != 1) begin
      nErrors++; $display("FAIL bp_done: got cycle %0d count %0d expected 18 1", doneCyc, doneCount);
    end
  endtask

  task automatic test_conflict;
    do_burst(10'd8, 10'd4, 0, -1, 0, 1, 0);
    nChecks++;
    if (stallBad != 0) begin nErrors++; $display("FAIL conflict_stall: got %0d bad cycles expected 0", stallBad); end
    nChecks++;
    if (gotQ.size() != 4 || gotQ[1] !== 32'h11 || ram[9] !== 32'h11) begin
      nErrors++; $display("FAIL conflict_ram9: got ram=%h expected 00000011", ram[9]);
    end
    @(negedge clk); #1;
    nChecks++;
    if (pipeStall !== 1'b0 || memWriteEnable !== 1'b1) begin
      nErrors++; $display("FAIL conflict_release: got stall=%b we=%b expected 0 1", pipeStall, memWriteEnable);
    end
    @(negedge clk);
    pipeMemWrite = 0;
    model[9] = 32'hAA;
    #1;
    nChecks++;
    if (ram[9] !== 32'hAA) begin nErrors++; $display("FAIL conflict_land: got %h expected 000000aa", ram[9]); end
  endtask

  task automatic test_zero_length;
    do_burst(10'd30, 10'd0, 0, -1, 0, 0, 0);
    nChecks++;
    if (doneCyc != 1 || doneCount != 1) begin
      nErrors++; $display("FAIL zero_done: got cycle %0d count %0d expected 1 1", doneCyc, doneCount);
    end
    nChecks++;
    if (gotQ.size() != 0 || addrQ.size() != 0 || validSeen != 0) begin
      nErrors++; $display("FAIL zero_reads: got words=%0d busyAddrs=%0d expected 0 0", gotQ.size(), addrQ.size());
    end
  endtask

  task automatic test_wrap;
    logic [9:0] expA [4];
    expA[0] = 10'h3FE; expA[1] = 10'h3FF; expA[2] = 10'h000; expA[3] = 10'h001;
    do_burst(10'h3FE, 10'd4, 0, -1, 0, 0, 0);
    nChecks++;
    if (addrQ.size() != 4) begin nErrors++; $display("FAIL wrap_naddr: got %0d expected 4", addrQ.size()); end
    for (int k = 0; k < 4 && k < addrQ.size() && k < gotQ.size(); k++) begin
      nChecks++;
      if (addrQ[k] !== expA[k] || gotQ[k] !== model[expA[k]]) begin
        nErrors++; $display("FAIL wrap_word%0d: got addr %h data %h expected addr %h data %h",
                            k, addrQ[k], gotQ[k], expA[k], model[expA[k]]);
      end
    end
  endtask

  task automatic test_restart_ignored;
    do_burst(10'd20, 10'd3, 0, -1, 0, 0, 1);
    nChecks++;
    if (gotQ.size() != 3 || gotQ[0] !== model[20] || gotQ[2] !== model[22] || doneCount != 1) begin
      nErrors++; $display("FAIL restart_words: got %0d words expected 3 from base 20", gotQ.size());
    end
    repeat (3) @(negedge clk);
    #1;
    nChecks++;
    if (dbgBusy !== 1'b0) begin nErrors++; $display("FAIL restart_queued: got busy=%b expected 0", dbgBusy); end
  endtask

  task automatic test_reset_mid_burst;
    int doneDuring = 0;
    @(negedge clk);
    dbgStart = 1; dbgBaseAddr = 10'd40; dbgLength = 10'd4; dbgDataReady = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      dbgStart = 0;
      if (c == 4) begin dbgDataReady = 0; pipeMemRead = 1; end
    end
    #1;
    nChecks++;
    if (dbgDataValid !== 1'b1 || pipeStall !== 1'b1 || dbgData !== model[41]) begin
      nErrors++; $display("FAIL midrst_pre: got valid=%b stall=%b data=%h expected 1 1 %h",
                          dbgDataValid, pipeStall, dbgData, model[41]);
    end
    #2 reset = 0;
    #1;
    nChecks++;
    if ({dbgDataValid, dbgBusy, dbgDone, pipeStall, memWriteEnable} !== 5'b0 || dbgData !== 32'h0) begin
      nErrors++; $display("FAIL midrst_outputs: got %b data=%h expected 00000 0",
                          {dbgDataValid, dbgBusy, dbgDone, pipeStall, memWriteEnable}, dbgData);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (dbgDone) doneDuring++;
    end
    nChecks++;
    if (doneDuring != 0) begin nErrors++; $display("FAIL midrst_done: got %0d pulses expected 0", doneDuring); end
    @(negedge clk);
    reset = 1; pipeMemRead = 0;
    do_burst(10'd200, 10'd3, 0, -1, 0, 0, 0);
    nChecks++;
    if (gotQ.size() != 3 || gotQ[0] !== model[200] || gotQ[1] !== model[201] || gotQ[2] !== model[202]) begin
      nErrors++; $display("FAIL midrst_fresh: got %0d words expected 3 from base 200", gotQ.size());
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      logic [9:0]  a, b, l;
      logic [31:0] d;
      int          bad;
      a = 10'($urandom); d = $urandom;
      @(negedge clk);
      pipeMemWrite = 1; pipeAddress = a; pipeWriteData = d;
      model[a] = d;
      @(negedge clk);
      pipeMemWrite = 0; pipeMemRead = 1;
      @(negedge clk);
      pipeMemRead = 0;
      #1;
      nChecks++;
      if (pipeReadData !== model[a]) begin
        nErrors++; $display("FAIL rnd_pipe%0d: got %h expected %h", it, pipeReadData, model[a]);
      end
      b = (it % 2 == 0) ? a - 10'($urandom_range(0, 3)) : 10'($urandom);
      l = 10'($urandom_range(1, 10));
      do_burst(b, l, 1, -1, 0, 0, 0);
      bad = 0;
      for (int k = 0; k < gotQ.size(); k++) if (gotQ[k] !== model[10'(b + 10'(k))]) bad++;
      nChecks++;
      if (gotQ.size() != int'(l) || bad != 0 || doneCount != 1 || holdBad != 0 || addrBad != 0) begin
        nErrors++; $display("FAIL rnd_burst%0d: got %0d words %0d wrong done=%0d hold=%0d addr=%0d expected %0d words",
                            it, gotQ.size(), bad, doneCount, holdBad, addrBad, l);
      end
    end
  endtask

  initial begin
    nChecks = 0; nErrors = 0;
    for (int i = 0; i < 1024; i++) model[i] = initVal(i);
    reset = 0; pipeMemRead = 0; pipeMemWrite = 0; pipeAddress = '0; pipeWriteData = '0;
    dbgStart = 0; dbgBaseAddr = '0; dbgLength = '0; dbgDataReady = 0;
    test_reset;
    test_pipeline;
    test_burst;
    test_backpressure;
    test_conflict;
    test_zero_length;
    test_wrap;
    test_restart_ignored;
    test_reset_mid_burst;
    test_random;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule

// File: doc/data_memory_debug_arbiter.md
Name: data_memory_debug_arbiter

Overview:
Sole owner of the single-port data memory's address, write-enable and write-data pins. It shares the memory between the pipeline MEM stage and the debug unit. The debug unit requests a burst dump of N consecutive words, and the block streams them out over a valid/ready handshake. While a burst is running, the block stalls any pipeline access. It sits between the MEM stage / trunk units and the data RAM; the debug UART/dump logic is the consumer.

Parameters:
Addr_B, 10, memory word-address width
Width_B, 32, data word width
Len_B, 10, burst length field width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pipeMemRead  in  1  MEM stage read request
pipeMemWrite  in  1  MEM stage write request
pipeAddress  in  Addr_B  MEM stage word address
pipeWriteData  in  Width_B  MEM stage write data (already trunked)
pipeReadData  out  Width_B  read data to load trunk unit
pipeStall  out  1  MEM stage must hold its request
dbgStart  in  1  start-burst pulse
dbgBaseAddr  in  Addr_B  first word address of burst
dbgLength  in  Len_B  number of words to dump
dbgData  out  Width_B  dumped word
dbgDataValid  out  1  dbgData holds a valid word
dbgDataReady  in  1  consumer accepts dbgData
dbgBusy  out  1  burst in progress
dbgDone  out  1  one-cycle pulse at end of burst
memWriteEnable  out  1  RAM write enable
memAddress  out  Addr_B  RAM address
memWriteData  out  Width_B  RAM write data
memReadData  in  Width_B  RAM read data, 1-cycle synchronous latency

Behaviour:
- Reset (reset low, async): state IDLE; counter, base, length, dbgData cleared. All outputs are 0: dbgDataValid, dbgBusy, dbgDone, pipeStall and memWriteEnable. Reset mid-burst aborts the burst with no dbgDone pulse.
- FSM states: IDLE, ISSUE, CAPTURE, OUT, DONE.
- IDLE:
  - Memory is driven combinationally by the pipeline: memAddress=pipeAddress, memWriteData=pipeWriteData, memWriteEnable=pipeMemWrite & ~pipeMemRead (read wins if both are set).
  - pipeStall=0.
  - dbgStart=1 latches dbgBaseAddr and dbgLength and clears the counter. A pipeline access in the same cycle is still served that cycle.
  - If the latched length is 0, go to DONE; otherwise go to ISSUE.
- ISSUE: memAddress=base+count (mod 2^Addr_B, wrap allowed), memWriteEnable=0. Next state is CAPTURE.
- CAPTURE: register memReadData into dbgData, set dbgDataValid. Next state is OUT.
- OUT:
  - dbgData and dbgDataValid hold stable until dbgDataReady=1.
  - On a handshake, dbgDataValid drops next cycle and count increments.
  - If count==length-1 at the handshake, go to DONE; otherwise go to ISSUE.
  - No new address is issued while the consumer backpressures.
- DONE: dbgDone=1 for exactly one cycle, then IDLE. dbgBusy=0 in this state.
- dbgBusy=1 in ISSUE, CAPTURE and OUT.
- Outside IDLE:
  - pipeStall = pipeMemRead | pipeMemWrite.
  - memWriteEnable=0 for pipeline requests; pipeline writes never reach the RAM during a burst.
- pipeReadData = memReadData at all times. It is meaningful to the pipeline only for IDLE-cycle reads.
- dbgStart outside IDLE is ignored (not queued).
- Throughput: 3 cycles/word with dbgDataReady held high. The first word is valid 2 cycles after the ISSUE cycle starts.
- Counter width is Len_B. Maximum burst is 2^Len_B-1 words.

Test Plan:
- Pipeline only: write 0xDEADBEEF to addr 5, then read addr 5 with burst idle -> memWriteEnable=1 for one cycle, pipeReadData=0xDEADBEEF next cycle, pipeStall never asserted.
- Burst of 4 from base 8 (RAM preloaded 8..11 = 0x10..0x13), dbgDataReady=1 -> dbgData sequence 0x10,0x11,0x12,0x13, one word every 3 cycles, dbgDone pulses once, dbgBusy low after.
- Backpressure: same burst with dbgDataReady low 5 cycles on word 2 -> dbgData=0x11 held stable with valid high, memAddress does not advance past 9, no words lost or duplicated.
- Conflict:
  - pipeMemWrite to addr 9 with value 0xAA during the burst -> pipeStall=1 throughout the burst and RAM[9] unchanged.
  - After dbgDone, the stall drops and the write lands the next IDLE cycle.
- Edge cases:
  - dbgLength=0 -> dbgDone one cycle after start, no RAM reads.
  - base=0x3FE with length 4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - dbgStart during a burst -> ignored.
- Reset mid-burst (reset low in OUT state after word 1) -> all outputs 0 immediately, no dbgDone. A fresh burst after reset release starts from the new base.
